debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 170 +++++++++++++++++
 tb/tb_debounce_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// Bank of independent push-button / switch conditioners. Every channel:
//   1. brings its raw input into the clk domain through a two-flop synchronizer,
//   2. debounces it with a DEB_W-bit stability counter (the new level must hold
//      for 2^DEB_W consecutive cycles before the debounced output follows),
//   3. emits registered one-cycle press / release pulses on output changes,
//   4. optionally generates auto-repeat pulses while the button is held
//      (first after REP_DELAY cycles, then every REP_PERIOD cycles).
//
// Parameters
//   CHANNELS   number of independent channels (>= 1)
//   DEB_W      debounce counter width; stable time is 2^DEB_W cycles
//   REP_DELAY  cycles from the start of a hold to the first repeat pulse (>= 1)
//   REP_PERIOD cycles between subsequent repeat pulses (>= 1)
//
// Ports
//   clk     in   1         single clock, all logic in this domain
//   rst_n   in   1         asynchronous active-low reset
//   in      in   CHANNELS  raw asynchronous inputs
//   rep_en  in   CHANNELS  per-channel auto-repeat enable (already synchronous)
//   out     out  CHANNELS  debounced level
//   ondn    out  CHANNELS  one-cycle pulse when out goes 0->1 (press)
//   onup    out  CHANNELS  one-cycle pulse when out goes 1->0 (release)
//   rep     out  CHANNELS  one-cycle auto-repeat pulse while held
//   any_dn  out  1         OR of all ondn bits, same cycle
// -----------------------------------------------------------------------------
module debounce_bank #(
    parameter int CHANNELS   = 4,
    parameter int DEB_W      = 18,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] rep_en,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] ondn,
    output logic [CHANNELS-1:0] onup,
    output logic [CHANNELS-1:0] rep,
    output logic                any_dn
);

    // Repeat counter only has to reach the larger of the two intervals.
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RC_W    = $clog2(REP_MAX + 1);

    // The pulse is registered, so it is scheduled one count early: a counter
    // value of N-1 in cycle t makes rep visible in cycle t+1 = start + N.
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REP_DELAY - 1);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REP_PERIOD - 1);

    typedef enum logic {
        PH_FIRST = 1'b0,    // waiting for the initial REP_DELAY interval
        PH_NEXT  = 1'b1     // waiting for a REP_PERIOD interval
    } phase_e;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch

            // ---------------------------------------------------------------
            // Channel state
            // ---------------------------------------------------------------
            logic             sync0_q;
            logic             sync1_q;
            logic [DEB_W-1:0] cnt_q;
            logic [DEB_W-1:0] cnt_d;
            logic             out_q;
            logic             out_d;
            logic             ondn_q;
            logic             ondn_d;
            logic             onup_q;
            logic             onup_d;
            logic             rep_q;
            logic             rep_d;
            logic [RC_W-1:0]  rc_q;
            logic [RC_W-1:0]  rc_d;
            phase_e           phase_q;
            phase_e           phase_d;

            logic             differ;
            logic             flip;
            logic             rc_hit;

            // ---------------------------------------------------------------
            // Debounce and edge detection
            // ---------------------------------------------------------------
            always_comb begin
                differ = (sync1_q != out_q);
                // The counter has seen 2^DEB_W differing cycles once it is
                // all-ones and the input still differs on this edge.
                flip   = differ && (&cnt_q);

                // Increment from all-ones wraps to 0, which is exactly the
                // post-toggle value; any agreeing cycle restarts the count.
                cnt_d  = differ ? (cnt_q + DEB_W'(1)) : '0;
                out_d  = out_q ^ flip;

                // Pulses go high in the first cycle the new level is visible.
                ondn_d = flip && !out_q;
                onup_d = flip &&  out_q;
            end

            // ---------------------------------------------------------------
            // Auto-repeat
            // ---------------------------------------------------------------
            always_comb begin
                rc_hit  = (phase_q == PH_FIRST) ? (rc_q == DELAY_LAST)
                                                : (rc_q == PERIOD_LAST);
                rc_d    = rc_q;
                phase_d = phase_q;
                rep_d   = 1'b0;

                if (!out_q || !rep_en[gi]) begin
                    // Not held or not enabled: forget any partial interval so
                    // the next hold starts from the full initial delay.
                    rc_d    = '0;
                    phase_d = PH_FIRST;
                end else if (rc_hit) begin
                    rc_d    = '0;
                    phase_d = PH_NEXT;
                    // A release on this same edge cancels the pending pulse, so
                    // rep can never share a cycle with onup.
                    rep_d   = !flip;
                end else begin
                    rc_d    = rc_q + RC_W'(1);
                end
            end

            // ---------------------------------------------------------------
            // Registers
            // ---------------------------------------------------------------
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync0_q <= 1'b0;
                    sync1_q <= 1'b0;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                    ondn_q  <= 1'b0;
                    onup_q  <= 1'b0;
                    rep_q   <= 1'b0;
                    rc_q    <= '0;
                    phase_q <= PH_FIRST;
                end else begin
                    sync0_q <= in[gi];
                    sync1_q <= sync0_q;
                    cnt_q   <= cnt_d;
                    out_q   <= out_d;
                    ondn_q  <= ondn_d;
                    onup_q  <= onup_d;
                    rep_q   <= rep_d;
                    rc_q    <= rc_d;
                    phase_q <= phase_d;
                end
            end

            assign out[gi]  = out_q;
            assign ondn[gi] = ondn_q;
            assign onup[gi] = onup_q;
            assign rep[gi]  = rep_q;
        end
    endgenerate

    // Built from registered pulses, so it is glitch-free and reads 0 in reset.
    assign any_dn = |ondn;

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    localparam int CH  = 4;
    localparam int DW  = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = (1 << DW) + 2;   // edges from input change to out change

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] in_v;
    logic [CH-1:0] rep_en_v;
    logic [CH-1:0] out_w;
    logic [CH-1:0] ondn_w;
    logic [CH-1:0] onup_w;
    logic [CH-1:0] rep_w;
    logic          any_dn_w;

    int total = 0;
    int bad   = 0;

    debounce_bank #(
        .CHANNELS  (CH),
        .DEB_W     (DW),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_v),
        .rep_en(rep_en_v),
        .out   (out_w),
        .ondn  (ondn_w),
        .onup  (onup_w),
        .rep   (rep_w),
        .any_dn(any_dn_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; afterwards outputs are stable and inputs may be driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a press (dn=1) or release (dn=0) pulse on channel ch.
    task automatic wait_pulse(input string tag, input int ch, input bit dn, output int n);
        bit found;
        found = 1'b0;
        n     = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            n++;
            if (dn ? ondn_w[ch] : onup_w[ch]) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    function automatic logic [16:0] all_out();
        return {out_w, ondn_w, onup_w, rep_w, any_dn_w};
    endfunction

    initial begin
        int  n;
        logic [15:0] seen;

        rst_n    = 1'b0;
        in_v     = '0;
        rep_en_v = '0;
        #1;
        chk("reset state", 32'(all_out()), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle after reset", 32'(all_out()), 32'd0);

        // ---- single press on channel 0: latency, pulse width, isolation ----
        in_v[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k < LAT) chk("t29 early", 32'({out_w, ondn_w, onup_w, rep_w}), 32'd0);
        end
        chk("t29 out", 32'(out_w), 32'h1);
        chk("t29 ondn", 32'(ondn_w), 32'h1);
        chk("t29 any_dn", 32'(any_dn_w), 32'd1);
        chk("t29 quiet", 32'({onup_w, rep_w}), 32'd0);
        step();
        chk("t29 ondn one cycle", 32'({ondn_w, any_dn_w}), 32'd0);
        chk("t29 out held", 32'(out_w), 32'h1);
        in_v[0] = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k < LAT) chk("t29 rel early", 32'(onup_w), 32'd0);
        end
        chk("t29 onup", 32'(onup_w), 32'h1);
        chk("t29 out low", 32'(out_w), 32'd0);
        step();
        chk("t29 onup one cycle", 32'(onup_w), 32'd0);
        $display("t29 press/release ch0 checked");

        // ---- bouncing channel 1: short excursions never change out ----
        seen = '0;
        for (int k = 0; k < 100; k++) begin
            if (k % 7 == 0) in_v[1] = ~in_v[1];
            step();
            seen |= {out_w, ondn_w, onup_w, rep_w};
        end
        in_v[1] = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            seen |= {out_w, ondn_w, onup_w, rep_w};
        end
        chk("t30 bounce quiet", 32'(seen), 32'd0);
        $display("t30 bounce ch1 checked");

        // ---- auto-repeat on channel 2, released while repeating ----
        rep_en_v[2] = 1'b1;
        in_v[2]     = 1'b1;
        wait_pulse("t31 wait ondn", 2, 1'b1, n);
        chk("t31 latency", 32'(n), 32'(LAT));
        for (int k = 1; k <= 45; k++) begin
            step();
            chk($sformatf("t31 rep k=%0d", k), 32'(rep_w[2]),
                32'(k == 20 || k == 25 || k == 30 || k == 35));
            chk($sformatf("t31 onup k=%0d", k), 32'(onup_w[2]), 32'(k == 37));
            if (k == 19) in_v[2] = 1'b0;   // out falls at t0+37
        end
        rep_en_v[2] = 1'b0;
        $display("t31 repeat ch2 checked");

        // ---- late enable on channel 3, then disable ----
        in_v[3] = 1'b1;
        wait_pulse("t32 wait ondn", 3, 1'b1, n);
        for (int k = 1; k <= 90; k++) begin
            step();
            chk($sformatf("t32 rep k=%0d", k), 32'(rep_w[3]), 32'(k == 70 || k == 75));
            if (k == 50) rep_en_v[3] = 1'b1;
            if (k == 76) rep_en_v[3] = 1'b0;
        end
        in_v[3] = 1'b0;
        wait_pulse("t32 wait onup", 3, 1'b0, n);
        $display("t32 late enable ch3 checked");
        step();

        // ---- all channels simultaneously ----
        in_v = 4'b1111;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k < LAT) chk("t33 early", 32'({ondn_w, any_dn_w}), 32'd0);
        end
        chk("t33 out", 32'(out_w), 32'hF);
        chk("t33 ondn", 32'(ondn_w), 32'hF);
        chk("t33 any_dn", 32'(any_dn_w), 32'd1);
        step();
        chk("t33 ondn one cycle", 32'({ondn_w, any_dn_w}), 32'd0);
        in_v = 4'b0000;
        for (int k = 1; k <= LAT; k++) step();
        chk("t33 onup", 32'(onup_w), 32'hF);
        chk("t33 out low", 32'(out_w), 32'd0);
        step();
        $display("t33 all channels checked");

        // ---- reset mid-count and while held ----
        in_v[0] = 1'b1;
        for (int k = 0; k < 8; k++) step();
        rst_n = 1'b0;
        #1;
        chk("t34 reset mid-count", 32'(all_out()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t34 in reset", 32'(all_out()), 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k < LAT) chk("t34 early 1", 32'({out_w, ondn_w, onup_w, rep_w}), 32'd0);
        end
        chk("t34 ondn after reset 1", 32'({out_w, ondn_w}), 32'h11);
        rep_en_v[0] = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("t34 held", 32'(out_w), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t34 reset while held", 32'(all_out()), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t34 in reset 2", 32'(all_out()), 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k < LAT) chk("t34 early 2", 32'({out_w, ondn_w, onup_w, rep_w}), 32'd0);
        end
        chk("t34 ondn after reset 2", 32'({out_w, ondn_w}), 32'h11);
        $display("t34 reset behaviour checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
